// File: rtl/dma_pcie_pkg.sv
// Shared definitions for the DMA read path: FSM encoding, DW length width,
// the 4 KB page size in DWs and the MRRS decode.
package dma_pcie_pkg;

  localparam int LEN_WIDTH = 16;
  localparam int DW_4K     = 1024;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CALC        = 3'd1,
    ST_ISSUE       = 3'd2,
    ST_WAIT_LOW    = 3'd3,
    ST_WAIT_CREDIT = 3'd4
  } state_t;

  // Max read request size in DWs: 128<<n bytes, codes above 5 saturate to 4 KB
  function automatic logic [10:0] mrrs_to_dw(input logic [2:0] mrrs);
    logic [2:0] n;
    n = (mrrs > 3'd5) ? 3'd5 : mrrs;
    return 11'd32 << n;
  endfunction

endpackage

// File: rtl/dma_chunk_calc.sv
// Combinational chunk size: smallest of remaining length, MRRS and the
// distance to the next 4 KB boundary. Result range is 1..1024 for a
// non-zero remaining length.
module dma_chunk_calc
  import dma_pcie_pkg::*;
#(
  parameter int P_LEN_WIDTH = LEN_WIDTH
) (
  input  logic [P_LEN_WIDTH-1:0] remaining,
  input  logic [2:0]             cfg_mrrs,
  input  logic [9:0]             addr_dw_lo,
  output logic [10:0]            chunk
);

  logic [10:0] mrrs_dw;
  logic [10:0] to_boundary;
  logic [10:0] rem_clip;
  logic [10:0] min_ab;

  // Three-way minimum; remaining is clipped to 1024 first so everything fits 11 bits
  always_comb begin
    mrrs_dw     = mrrs_to_dw(cfg_mrrs);
    to_boundary = 11'(DW_4K) - {1'b0, addr_dw_lo};
    if (32'(remaining) > 32'(DW_4K)) begin
      rem_clip = 11'(DW_4K);
    end else begin
      rem_clip = 11'(remaining);
    end
    min_ab = (rem_clip < mrrs_dw) ? rem_clip : mrrs_dw;
    chunk  = (min_ab < to_boundary) ? min_ab : to_boundary;
  end

endmodule

// File: rtl/dma_read_splitter.sv
// Splits a DMA read command into MRRS-sized, 4 KB-safe read requests,
// handshakes each with the TX engine and tracks outstanding credits.
//
//   state       | meaning
//   ------------+----------------------------------------------------
//   IDLE        | ready for a command
//   CALC        | register next chunk size and request address/len
//   ISSUE       | request presented, waiting for dma_read_done
//   WAIT_LOW    | request taken, waiting for dma_read_done to drop
//   WAIT_CREDIT | outstanding limit reached, waiting for a completion
module dma_read_splitter
  import dma_pcie_pkg::*;
#(
  parameter int P_MAX_OUTSTANDING = 8,
  parameter int P_LEN_WIDTH       = LEN_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [31:0]            cmd_addr,
  input  logic [P_LEN_WIDTH-1:0] cmd_len_dw,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cfg_mrrs,
  output logic [31:0]            dma_read_addr,
  output logic [9:0]             dma_read_len,
  output logic                   dma_read_valid,
  input  logic                   dma_read_done,
  input  logic [7:0]             current_tag,
  output logic [7:0]             issued_tag,
  output logic                   issued_tag_valid,
  input  logic                   cpl_tag_done,
  output logic [5:0]             outstanding,
  output logic                   cmd_done,
  output logic                   busy
);

  state_t                 state_q, state_d;
  logic [29:0]            addr_q;
  logic [P_LEN_WIDTH-1:0] remaining_q;
  logic [10:0]            chunk_q;
  logic [10:0]            chunk_calc;

  logic accept;
  logic issue_hs;
  logic credit_full;
  logic cpl_dec;

  logic cmd_ready_d;
  logic busy_d;
  logic valid_d;
  logic tag_valid_d;
  logic cmd_done_d;

  assign accept      = (state_q == ST_IDLE) && cmd_ready && cmd_valid;
  assign issue_hs    = (state_q == ST_ISSUE) && dma_read_done;
  assign credit_full = (outstanding >= 6'(P_MAX_OUTSTANDING));
  assign cpl_dec     = cpl_tag_done && (outstanding != 6'd0);

  dma_chunk_calc #(
    .P_LEN_WIDTH (P_LEN_WIDTH)
  ) u_chunk_calc (
    .remaining  (remaining_q),
    .cfg_mrrs   (cfg_mrrs),
    .addr_dw_lo (addr_q[9:0]),
    .chunk      (chunk_calc)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (cmd_len_dw != '0)) state_d = ST_CALC;
      end
      ST_CALC: begin
        state_d = credit_full ? ST_WAIT_CREDIT : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (dma_read_done) state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!dma_read_done) state_d = (remaining_q == '0) ? ST_IDLE : ST_CALC;
      end
      ST_WAIT_CREDIT: begin
        if (!credit_full) state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered control outputs, derived from the upcoming state
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    valid_d     = (state_d == ST_ISSUE);
    tag_valid_d = issue_hs;
    cmd_done_d  = (accept && (cmd_len_dw == '0)) ||
                  ((state_q == ST_WAIT_LOW) && !dma_read_done && (remaining_q == '0));
  end

  // Registered control outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_ready        <= 1'b0;
      busy             <= 1'b0;
      dma_read_valid   <= 1'b0;
      issued_tag_valid <= 1'b0;
      cmd_done         <= 1'b0;
    end else begin
      cmd_ready        <= cmd_ready_d;
      busy             <= busy_d;
      dma_read_valid   <= valid_d;
      issued_tag_valid <= tag_valid_d;
      cmd_done         <= cmd_done_d;
    end
  end

  // Command datapath: address/length bookkeeping and the request fields
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q        <= '0;
      remaining_q   <= '0;
      chunk_q       <= '0;
      dma_read_addr <= '0;
      dma_read_len  <= '0;
      issued_tag    <= '0;
    end else begin
      if (accept) begin
        addr_q      <= cmd_addr[31:2];
        remaining_q <= cmd_len_dw;
      end
      if (state_q == ST_CALC) begin
        chunk_q       <= chunk_calc;
        dma_read_addr <= {addr_q, 2'b00};
        dma_read_len  <= chunk_calc[9:0];
      end
      if (issue_hs) begin
        addr_q      <= addr_q + 30'(chunk_q);
        remaining_q <= remaining_q - P_LEN_WIDTH'(chunk_q);
        issued_tag  <= current_tag;
      end
    end
  end

  // Outstanding credit counter; a completion with nothing outstanding is dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      outstanding <= '0;
    end else begin
      case ({issue_hs, cpl_dec})
        2'b10:   outstanding <= outstanding + 6'd1;
        2'b01:   outstanding <= outstanding - 6'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_read_splitter.sv
// Directed bench for dma_read_splitter: one instance with the default credit
// limit for the splitting scenarios, one with a limit of 2 for credit stalls.
module tb_dma_read_splitter;

  logic        clk;
  logic        rst_n;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len_dw;
  logic [2:0]  cfg_mrrs;
  logic [7:0]  current_tag;

  logic        cmd_valid, cmd_ready;
  logic [31:0] dma_read_addr;
  logic [9:0]  dma_read_len;
  logic        dma_read_valid, dma_read_done;
  logic [7:0]  issued_tag;
  logic        issued_tag_valid, cpl_tag_done;
  logic [5:0]  outstanding;
  logic        cmd_done, busy;

  logic        b_cmd_valid, b_cmd_ready;
  logic [31:0] b_read_addr;
  logic [9:0]  b_read_len;
  logic        b_read_valid, b_read_done;
  logic [7:0]  b_issued_tag;
  logic        b_tag_valid, b_cpl;
  logic [5:0]  b_outstanding;
  logic        b_cmd_done, b_busy;

  int vectors     = 0;
  int miscompares = 0;

  dma_read_splitter dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .cmd_addr (cmd_addr), .cmd_len_dw (cmd_len_dw), .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready), .cfg_mrrs (cfg_mrrs),
    .dma_read_addr (dma_read_addr), .dma_read_len (dma_read_len),
    .dma_read_valid (dma_read_valid), .dma_read_done (dma_read_done),
    .current_tag (current_tag), .issued_tag (issued_tag),
    .issued_tag_valid (issued_tag_valid), .cpl_tag_done (cpl_tag_done),
    .outstanding (outstanding), .cmd_done (cmd_done), .busy (busy)
  );

  dma_read_splitter #(.P_MAX_OUTSTANDING (2)) dut_b (
    .i_clk (clk), .i_rst_n (rst_n),
    .cmd_addr (cmd_addr), .cmd_len_dw (cmd_len_dw), .cmd_valid (b_cmd_valid),
    .cmd_ready (b_cmd_ready), .cfg_mrrs (cfg_mrrs),
    .dma_read_addr (b_read_addr), .dma_read_len (b_read_len),
    .dma_read_valid (b_read_valid), .dma_read_done (b_read_done),
    .current_tag (current_tag), .issued_tag (b_issued_tag),
    .issued_tag_valid (b_tag_valid), .cpl_tag_done (b_cpl),
    .outstanding (b_outstanding), .cmd_done (b_cmd_done), .busy (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of stimulus, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [15:0] len, input logic [2:0] mrrs);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_addr = addr; cmd_len_dw = len; cfg_mrrs = mrrs; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'(len != 16'd0));
    if (len == 16'd0) begin
      check("cmd_done_zero_len", 32'(cmd_done), 32'd1);
      @(negedge clk);
      check("cmd_done_pulse", 32'(cmd_done), 32'd0);
    end
  endtask

  task automatic issue_chunk(input logic [31:0] exp_addr, input logic [9:0] exp_len,
                             input logic [7:0] tag, input int delay, input int hold,
                             input logic with_cpl, input logic exp_last, input logic [5:0] exp_out);
    int n = 0;
    while (!dma_read_valid && n < 50) begin @(negedge clk); n++; end
    check("req_valid", 32'(dma_read_valid), 32'd1);
    check("req_addr", dma_read_addr, exp_addr);
    check("req_len", 32'(dma_read_len), 32'(exp_len));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("req_valid_stable", 32'(dma_read_valid), 32'd1);
      check("req_addr_stable", dma_read_addr, exp_addr);
    end
    current_tag = tag; dma_read_done = 1'b1; cpl_tag_done = with_cpl;
    @(negedge clk);
    current_tag = ~tag; cpl_tag_done = 1'b0;
    check("tag_valid", 32'(issued_tag_valid), 32'd1);
    check("issued_tag", 32'(issued_tag), 32'(tag));
    check("valid_fall", 32'(dma_read_valid), 32'd0);
    check("outstanding_inc", 32'(outstanding), 32'(exp_out));
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check("valid_low_while_done", 32'(dma_read_valid), 32'd0);
      check("tag_valid_one_cycle", 32'(issued_tag_valid), 32'd0);
      check("issued_tag_hold", 32'(issued_tag), 32'(tag));
    end
    dma_read_done = 1'b0;
    @(negedge clk);
    check("cmd_done", 32'(cmd_done), 32'(exp_last));
    check("busy", 32'(busy), 32'(!exp_last));
  endtask

  task automatic retire(input int count);
    for (int i = 0; i < count; i++) begin
      cpl_tag_done = 1'b1;
      @(negedge clk);
      cpl_tag_done = 1'b0;
    end
    check("outstanding_retired", 32'(outstanding), 32'd0);
  endtask

  initial begin
    int seen;
    int n;
    rst_n = 1'b0;
    cmd_addr = '0; cmd_len_dw = '0; cfg_mrrs = '0; current_tag = '0;
    cmd_valid = 1'b0; dma_read_done = 1'b0; cpl_tag_done = 1'b0;
    b_cmd_valid = 1'b0; b_read_done = 1'b0; b_cpl = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(dma_read_valid), 32'd0);
    check("rst_addr", dma_read_addr, 32'd0);
    check("rst_len", 32'(dma_read_len), 32'd0);
    check("rst_tag", 32'(issued_tag), 32'd0);
    check("rst_tag_valid", 32'(issued_tag_valid), 32'd0);
    check("rst_cmd_done", 32'(cmd_done), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(cmd_ready), 32'd1);

    // 256 DW at 0x1000, 128-byte MRRS: eight 32-DW requests; first one held off and stretched
    send_cmd(32'h0000_1000, 16'd256, 3'd0);
    for (int i = 0; i < 8; i++) begin
      issue_chunk(32'h0000_1000 + 32'(i) * 32'h80, 10'd32, 8'h10 + 8'(i),
                  (i == 0) ? 2 : 0, (i == 0) ? 5 : 1, 1'b0, (i == 7), 6'(i + 1));
    end
    retire(8);
    cpl_tag_done = 1'b1;
    @(negedge clk);
    cpl_tag_done = 1'b0;
    check("no_underflow", 32'(outstanding), 32'd0);

    // 4 KB split: 0xF80 + 64 DW, 512-byte MRRS
    send_cmd(32'h0000_0F80, 16'd64, 3'd2);
    issue_chunk(32'h0000_0F80, 10'd32, 8'h21, 0, 1, 1'b0, 1'b0, 6'd1);
    issue_chunk(32'h0000_1000, 10'd32, 8'h22, 0, 1, 1'b0, 1'b1, 6'd2);
    retire(2);

    // Full 4 KB in one request, length field encodes 1024 as 0
    send_cmd(32'h0000_0000, 16'd1024, 3'd5);
    issue_chunk(32'h0000_0000, 10'd0, 8'h31, 0, 1, 1'b0, 1'b1, 6'd1);
    retire(1);

    // MRRS code 7 saturates to 1024 DW; boundary, MRRS and remainder each limit a chunk
    send_cmd(32'h0000_0100, 16'd2000, 3'd7);
    issue_chunk(32'h0000_0100, 10'h3C0, 8'h41, 0, 1, 1'b0, 1'b0, 6'd1);
    issue_chunk(32'h0000_1000, 10'd0, 8'h42, 0, 1, 1'b0, 1'b0, 6'd2);
    issue_chunk(32'h0000_2000, 10'd16, 8'h43, 0, 1, 1'b0, 1'b1, 6'd3);
    retire(3);

    // Address wrap past 0xFFFF_FFFF; completion coinciding with issue leaves count flat
    send_cmd(32'hFFFF_FFC0, 16'd32, 3'd0);
    issue_chunk(32'hFFFF_FFC0, 10'd16, 8'h51, 0, 1, 1'b0, 1'b0, 6'd1);
    issue_chunk(32'h0000_0000, 10'd16, 8'h52, 0, 1, 1'b1, 1'b1, 6'd1);
    retire(1);

    // Zero-length command is a no-op with a cmd_done pulse
    send_cmd(32'h0000_1234, 16'd0, 3'd0);

    // Credit stall on the limit-2 instance
    cmd_addr = 32'h0; cmd_len_dw = 16'd128; cfg_mrrs = 3'd0; b_cmd_valid = 1'b1;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!b_read_valid && n < 50) begin @(negedge clk); n++; end
      check("b_req_valid", 32'(b_read_valid), 32'd1);
      check("b_req_addr", b_read_addr, 32'(k) * 32'h80);
      check("b_req_len", 32'(b_read_len), 32'd32);
      current_tag = 8'hA0 + 8'(k); b_read_done = 1'b1;
      @(negedge clk);
      check("b_issued_tag", 32'(b_issued_tag), 32'hA0 + 32'(k));
      check("b_outstanding", 32'(b_outstanding), 32'(k + 1));
      b_read_done = 1'b0;
      @(negedge clk);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (b_read_valid) seen++;
    end
    check("b_stall_no_valid", 32'(seen), 32'd0);
    check("b_stall_outstanding", 32'(b_outstanding), 32'd2);
    check("b_stall_busy", 32'(b_busy), 32'd1);
    b_cpl = 1'b1;
    @(negedge clk);
    b_cpl = 1'b0;
    check("b_after_cpl", 32'(b_outstanding), 32'd1);
    n = 0;
    while (!b_read_valid && n < 50) begin @(negedge clk); n++; end
    check("b_third_valid", 32'(b_read_valid), 32'd1);
    check("b_third_addr", b_read_addr, 32'h100);
    current_tag = 8'hA2; b_read_done = 1'b1;
    @(negedge clk);
    check("b_third_tag", 32'(b_issued_tag), 32'hA2);
    check("b_third_outstanding", 32'(b_outstanding), 32'd2);
    b_read_done = 1'b0;

    // Reset while a request is presented
    send_cmd(32'h0000_3000, 16'd64, 3'd0);
    issue_chunk(32'h0000_3000, 10'd32, 8'h61, 0, 1, 1'b0, 1'b0, 6'd1);
    n = 0;
    while (!dma_read_valid && n < 50) begin @(negedge clk); n++; end
    check("pre_reset_valid", 32'(dma_read_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(dma_read_valid), 32'd0);
    check("async_rst_outstanding", 32'(outstanding), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(cmd_ready), 32'd0);
    check("async_rst_addr", dma_read_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_cmd(32'h0000_2000, 16'd32, 3'd0);
    issue_chunk(32'h0000_2000, 10'd32, 8'h71, 0, 1, 1'b0, 1'b1, 6'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
